bcd_to_bin_converter_n: RTL and testbench
=========================================

# bcd_to_bin_converter_n

Parametrised, multi-digit, packed-BCD to unsigned-binary converter for the calculator datapath, where keypad or display BCD is turned into binary operands. Digits are processed most-significant first, one per clock, using acc*10 + digit with shift-and-add (acc<<3 + acc<<1). Valid/ready handshakes are used on both sides, so the block can sit between the keypad entry buffer and the ALU operand registers.

## Interface
- DIGITS, 4, number of BCD digits in the input word (>= 1)
- BIN_W, 14, binary result width; must be >= ceil(log2(10^DIGITS)); elaboration error otherwise
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_bcd  input  4*DIGITS  packed BCD, digit DIGITS-1 in MSBs
- in_valid  input  1  in_bcd valid
- in_ready  output  1  block idle and able to accept
- out_bin  output  BIN_W  binary result
- out_err  output  1  at least one input digit > 9 (see Configuration)
- out_valid  output  1  out_bin/out_err valid
- out_ready  input  1  consumer accepts result

## Operation
- States are IDLE, CONV and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: capture in_bcd into the digit shift register, clear acc, clear err and digit counter, go to CONV.
- **CONV**
  - Each cycle: acc <= acc*10 + top digit; shift the digit register left by 4; increment the counter.
  - After DIGITS cycles, go to DONE.
  - in_ready = 0; in_valid is ignored.
- **DONE**
  - out_valid = 1.
  - out_bin and out_err are held stable until out_valid && out_ready, then go to IDLE.
  - in_ready = 0 in this state.
- **Arithmetic**
  - acc is BIN_W bits, unsigned.
  - The intermediate product uses BIN_W+4 bits and is truncated to BIN_W.
  - With a legal BIN_W and valid digits, no overflow is possible.
- **Reset**
  - Reset is asserted asynchronously at any time, including mid-CONV.
  - Reset values: state = IDLE, acc = 0, out_bin = 0, out_err = 0, out_valid = 0.
  - in_ready = 1 from the first edge after release.
  - A conversion in progress when reset is asserted is discarded.
- in_ready is decoded from state only; there is no combinational path from out_ready.

## Timing
- Acceptance is edge T0. CONV spans edges T1..T(DIGITS). out_valid is high after edge T(DIGITS), giving a latency of DIGITS cycles.
- With out_ready held high, DONE lasts 1 cycle. in_ready rises the next cycle, so the minimum period is DIGITS+2 cycles per conversion.
- out_bin is registered; it updates only on entry to DONE.

## Configuration
- The macro is BCD_DIGIT_CHECK_EN.
- **Defined**
  - Each digit is compared > 9 as it is consumed in CONV, and any hit sets a sticky err.
  - In DONE, out_err = err. When err = 1, out_bin is forced to 0.
- **Undefined**
  - out_err is tied to 0.
  - Illegal digits (A–F) are used arithmetically at face value (weight 10^k), and the result is truncated modulo 2^BIN_W.
- Latency is identical in both builds.

## Structure
- Shared package bcd_pkg:
  - state enum (IDLE, CONV, DONE)
  - BCD_DIGIT_W = 4
  - constant function bcd_min_bin_w(digits) used for the BIN_W check
- Sub-module bcd_digit_step (combinational):
  - Inputs: acc and digit.
  - Outputs: acc*10 + digit truncated to BIN_W, plus a digit_illegal flag.
  - The top level holds the FSM, registers and handshakes.

## Test plan
All scenarios use DIGITS = 4 and BIN_W = 14.
- **Maximum value:** reset, then in_bcd = 16'h9999 accepted at T0 -> out_valid after T4, out_bin = 9999 (14'h270F), out_err = 0.
- **Zero and leading zeros:** 16'h0000 -> 0; 16'h0042 -> 42; each with latency 4 cycles.
- **Backpressure:** 16'h1234 with out_ready = 0 for 5 cycles -> out_valid high and out_bin = 1234 stable; in_ready = 0; a pulse on in_valid is ignored. Raising out_ready -> in_ready = 1 on the next cycle.
- **Illegal digit:** 16'h12A4 -> with BCD_DIGIT_CHECK_EN: out_err = 1, out_bin = 0; without: out_err = 0, out_bin = 1304.
- **Reset mid-conversion:** rst_n low at T2 of 16'h5678 -> out_valid = 0 and out_bin = 0 immediately. After release, 16'h0007 -> 7, with no trace of 5678.
- **Back-to-back:** out_ready held 1, in_valid held 1 with 16'h0100 then 16'h2500 -> results 100 then 2500, accepted 6 cycles apart.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// Holds the FSM state encoding and the minimum result width helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest width able to hold 10^digits - 1, i.e. ceil(log2(10^digits)).
  function automatic int bcd_min_bin_w(input int digits);
    logic [255:0] pow10;
    int           width;
    pow10 = 256'd1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * 256'd10;
    width = 0;
    for (int b = 0; b < 256; b++) begin
      if ((256'd1 << b) < pow10) width = b + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One Horner step of the conversion: acc*10 + digit, built from two shifts
// and an add, plus a flag for digit values outside 0..9.
module bcd_digit_step
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       acc_next,
  output logic                   digit_illegal
);

  // Product is formed four bits wider than acc, then truncated back.
  assign acc_next = BIN_W'(({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                           + (BIN_W + 4)'(digit));

  assign digit_illegal = (digit > 4'd9);

endmodule

// File: rtl/bcd_to_bin_converter_n.sv
// Multi-digit packed-BCD to unsigned binary converter, MSD first, one digit per clock.
// Optional digit range checking is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin_converter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BIN_W-1:0]              out_bin,
  output logic                          out_err,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int IN_W  = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  if (DIGITS < 1) begin : g_digits_chk
    $error("bcd_to_bin_converter_n: DIGITS must be >= 1");
  end
  if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_width_chk
    $error("bcd_to_bin_converter_n: BIN_W too small for DIGITS");
  end

  state_t            state, state_next;
  logic [IN_W-1:0]   digits_q;
  logic [BIN_W-1:0]  acc_q;
  logic [BIN_W-1:0]  step_acc;
  logic [BIN_W-1:0]  out_bin_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              err_next;
  logic              out_err_q;
  logic              step_illegal;

  bcd_digit_step #(.BIN_W(BIN_W)) u_step (
    .acc          (acc_q),
    .digit        (digits_q[IN_W-1 -: BCD_DIGIT_W]),
    .acc_next     (step_acc),
    .digit_illegal(step_illegal)
  );

  // Sticky error including the digit being consumed this cycle; constant 0 when checking is off.
  assign err_next = CHECK_EN & (err_q | step_illegal);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)          state_next = CONV;
      CONV:    if (cnt_q == LAST_CNT) state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_bin   = out_bin_q;
  assign out_err   = out_err_q;

  // NOTE: the digit shift register is only a few flops, so it is reset along with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_bin_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          digits_q <= in_bcd;
          acc_q    <= '0;
          cnt_q    <= '0;
          err_q    <= 1'b0;
        end
        CONV: begin
          acc_q    <= step_acc;
          digits_q <= digits_q << BCD_DIGIT_W;
          cnt_q    <= cnt_q + 1'b1;
          err_q    <= err_next;
          if (cnt_q == LAST_CNT) begin
            out_bin_q <= err_next ? '0 : step_acc;
            out_err_q <= err_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_converter_n.sv
// Self-checking bench for bcd_to_bin_converter_n (DIGITS=4, BIN_W=14): directed
// scenarios plus randomized conversions against a weighted-sum reference model.
module tb_bcd_to_bin_converter_n;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       in_bcd;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  out_bin;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bcd_to_bin_converter_n #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_bcd   (in_bcd),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_bin  (out_bin),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: sum of digit * 10^position, reduced modulo 2^BIN_W.
  function automatic logic [BIN_W:0] ref_model(input logic [15:0] bcd);
    longint unsigned value  = 0;
    longint unsigned weight = 1;
    bit              bad    = 0;
    logic [3:0]      d;
    for (int k = 0; k < DIGITS; k++) begin
      d = bcd[4*k +: 4];
      value += longint'(d) * weight;
      weight *= 10;
      if (d > 4'd9) bad = 1;
    end
`ifdef BCD_DIGIT_CHECK_EN
    if (bad) return {1'b1, {BIN_W{1'b0}}};
`else
    bad = 0;
`endif
    return {bad, BIN_W'(value % (longint'(1) << BIN_W))};
  endfunction

  task automatic wait_ready(input string tag);
    int i;
    for (i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Full transaction: accept, measure latency, hold under backpressure, release.
  task automatic run_conv(input logic [15:0] bcd, input logic [BIN_W-1:0] exp_bin,
                          input logic exp_err, input int hold, input string tag);
    int lat;
    wait_ready(tag);
    in_bcd   = bcd;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, DIGITS);
    check({tag, "_bin"}, out_bin, exp_bin);
    check({tag, "_err"}, out_err, exp_err);
    check({tag, "_in_ready_done"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        in_valid = 1'b1;
        in_bcd   = 16'h8888;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_bin"}, out_bin, exp_bin);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released_valid"}, out_valid, 0);
    check({tag, "_released_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [15:0]      bcd;
    logic [BIN_W:0]   exp;
    int               t_a, t_b, i;

    rst_n     = 1'b0;
    in_bcd    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bin", out_bin, 0);
    check("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    run_conv(16'h9999, 14'd9999, 1'b0, 0, "max");
    run_conv(16'h0000, 14'd0,    1'b0, 0, "zero");
    run_conv(16'h0042, 14'd42,   1'b0, 0, "lead0");
    run_conv(16'h1234, 14'd1234, 1'b0, 5, "bp");
`ifdef BCD_DIGIT_CHECK_EN
    run_conv(16'h12A4, 14'd0,    1'b1, 0, "illegal");
`else
    run_conv(16'h12A4, 14'd1304, 1'b0, 0, "illegal");
`endif

    // Reset asserted two edges into a conversion.
    wait_ready("midrst");
    in_bcd   = 16'h5678;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_bin", out_bin, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_conv(16'h0007, 14'd7, 1'b0, 0, "after_rst");

    // Back-to-back with both handshakes held high; sampled on the falling edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = 16'h0100;
    @(negedge clk);
    for (i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    t_a = cyc;
    @(posedge clk); #1;
    in_bcd = 16'h2500;
    @(negedge clk);
    for (i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("b2b_first_bin", out_bin, 100);
    @(negedge clk);
    for (i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    t_b = cyc;
    check("b2b_spacing", t_b - t_a, DIGITS + 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    for (i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("b2b_second_bin", out_bin, 2500);
    check("b2b_second_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Randomized conversions, occasionally with illegal nibbles and backpressure.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < DIGITS; k++) begin
        if ($urandom_range(0, 7) == 0) bcd[4*k +: 4] = 4'($urandom_range(10, 15));
        else                           bcd[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      exp = ref_model(bcd);
      run_conv(bcd, exp[BIN_W-1:0], exp[BIN_W], int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
